uart_rx_ctrl: RTL and testbench

//  Controller and host-side buffer for the UART receiver.
//  - Drives baud_sel and line_control_reg into the receiver; applies new config only while the receiver is idle.
//  - Captures each completed byte and its corrupted flag into a FIFO, with a valid/ready read port.
//  - Tracks overrun and raises level interrupts for threshold and timeout.

---
 rtl/uart_rx_ctrl_if.sv | 11 +
 rtl/uart_rx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Host read port of the UART receive buffer: first-word fall-through head
// with a valid/ready handshake.
interface uart_rx_ctrl_if;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_err;

  modport master (output rd_valid, output rd_data, output rd_err, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_err, output rd_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: gated configuration hand-off, byte capture into a
// first-word fall-through FIFO, overrun tracking, threshold/timeout interrupts.
module uart_rx_ctrl #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int THRESH  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk_rx,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_baud_sel,
  input  logic [4:0]    cfg_lcr,
  output logic          cfg_busy,
  output logic [1:0]    baud_sel,
  output logic [4:0]    line_control_reg,
  output logic          rx_clr,
  input  logic          rx_active,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic          rx_corrupt,
  uart_rx_ctrl_if.master rd,
  output logic [AW:0]   fifo_count,
  output logic          overrun,
  input  logic          clr_overrun,
  output logic          irq_thresh,
  output logic          irq_timeout
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   THRESH_CNT = (AW + 1)'(THRESH);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
  localparam logic [4:0]    LCR_RESET  = 5'b00011;

  typedef enum logic [1:0] {CFG_IDLE, CFG_WAIT, CFG_APPLY} cfg_state_t;

  cfg_state_t state_reg, state_next;
  logic [1:0] baud_reg, shadow_baud_reg;
  logic [4:0] lcr_reg, shadow_lcr_reg;
  logic       cfg_apply;
  logic       apply_d_reg;

  // ---------------- configuration FSM ----------------
  always_ff @(posedge clk_rx) begin
    if (rst) state_reg <= CFG_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CFG_IDLE:  if (cfg_wr)     state_next = CFG_WAIT;
      CFG_WAIT:  if (!rx_active) state_next = CFG_APPLY;
      CFG_APPLY: state_next = CFG_IDLE;
      default:   state_next = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg_busy  = 1'b0;
    rx_clr    = 1'b0;
    cfg_apply = 1'b0;
    case (state_reg)
      CFG_WAIT:  cfg_busy = 1'b1;
      CFG_APPLY: begin
        cfg_busy  = 1'b1;
        rx_clr    = 1'b1;
        cfg_apply = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      shadow_baud_reg <= 2'b00;
      shadow_lcr_reg  <= LCR_RESET;
      baud_reg        <= 2'b00;
      lcr_reg         <= LCR_RESET;
      apply_d_reg     <= 1'b0;
    end else begin
      if (state_reg == CFG_IDLE && cfg_wr) begin
        shadow_baud_reg <= cfg_baud_sel;
        shadow_lcr_reg  <= cfg_lcr;
      end
      if (cfg_apply) begin
        baud_reg <= shadow_baud_reg;
        lcr_reg  <= shadow_lcr_reg;
      end
      apply_d_reg <= cfg_apply;
    end
  end

  assign baud_sel         = baud_reg;
  assign line_control_reg = lcr_reg;

  // ---------------- rx_done synchroniser and rise detect ----------------
  // Stages 0/1 synchronise, stage 2 holds the previous synchronised level.
  logic done_pipe_reg [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_done_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_rx) begin
          if (rst) done_pipe_reg[gi] <= 1'b0;
          else     done_pipe_reg[gi] <= rx_done;
        end
      end else begin : g_rest
        always_ff @(posedge clk_rx) begin
          if (rst) done_pipe_reg[gi] <= 1'b0;
          else     done_pipe_reg[gi] <= done_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  logic       push_req;
  logic [8:0] push_word;

  // The receiver holds its data while rx_done is high, so the byte is taken
  // directly from the port on the rise-detect cycle.
  assign push_req  = done_pipe_reg[1] & ~done_pipe_reg[2] & ~cfg_apply & ~apply_d_reg;
  assign push_word = {rx_corrupt, rx_data};

  // ---------------- FIFO ----------------
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr_next;
  logic [AW:0]   count_reg;
  logic [8:0]    head_reg;
  logic          full, pop, wr_en, overrun_evt;
  logic          overrun_reg;
  logic [TW-1:0] tmo_reg;

  assign full         = (count_reg == FULL_CNT);
  assign rd.rd_valid  = (count_reg != '0);
  assign pop          = rd.rd_valid & rd.rd_ready;
  assign wr_en        = push_req & (~full | pop);
  assign overrun_evt  = push_req & full & ~pop;
  assign rd_addr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_ff @(posedge clk_rx) begin
    if (wr_en) mem[wr_ptr_reg] <= push_word;
  end

  // Head register: registered read of the next head slot, bypassing the
  // incoming word when it becomes the head in the same cycle.
  always_ff @(posedge clk_rx) begin
    if (rst)                                  head_reg <= '0;
    else if (wr_en && wr_ptr_reg == rd_addr_next) head_reg <= push_word;
    else                                      head_reg <= mem[rd_addr_next];
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_addr_next;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd.rd_data = rd.rd_valid ? head_reg[7:0] : 8'h00;
  assign rd.rd_err  = rd.rd_valid ? head_reg[8]   : 1'b0;
  assign fifo_count = count_reg;

  // ---------------- overrun and interrupts ----------------
  always_ff @(posedge clk_rx) begin
    if (rst)              overrun_reg <= 1'b0;
    else if (overrun_evt) overrun_reg <= 1'b1;
    else if (clr_overrun) overrun_reg <= 1'b0;
  end

  always_ff @(posedge clk_rx) begin
    if (rst)                                   tmo_reg <= '0;
    else if (wr_en || pop || count_reg == '0)  tmo_reg <= '0;
    else if (tmo_reg != TMO_MAX)               tmo_reg <= tmo_reg + TW'(1);
  end

  assign overrun     = overrun_reg;
  assign irq_thresh  = (count_reg >= THRESH_CNT);
  assign irq_timeout = (tmo_reg == TMO_MAX);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table vectors, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16, AW = 4, THRESH = 8, TIMEOUT = 4096;

  logic clk_rx = 1'b0;
  always #5 clk_rx = ~clk_rx;

  logic          rst, cfg_wr, cfg_busy, rx_clr, rx_active, rx_done, rx_corrupt;
  logic [1:0]    cfg_baud_sel, baud_sel;
  logic [4:0]    cfg_lcr, line_control_reg;
  logic [7:0]    rx_data;
  logic [AW:0]   fifo_count;
  logic          overrun, clr_overrun, irq_thresh, irq_timeout;

  uart_rx_ctrl_if rd_if ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
    .clk_rx(clk_rx), .rst(rst), .cfg_wr(cfg_wr), .cfg_baud_sel(cfg_baud_sel),
    .cfg_lcr(cfg_lcr), .cfg_busy(cfg_busy), .baud_sel(baud_sel),
    .line_control_reg(line_control_reg), .rx_clr(rx_clr), .rx_active(rx_active),
    .rx_done(rx_done), .rx_data(rx_data), .rx_corrupt(rx_corrupt), .rd(rd_if),
    .fifo_count(fifo_count), .overrun(overrun), .clr_overrun(clr_overrun),
    .irq_thresh(irq_thresh), .irq_timeout(irq_timeout)
  );

  int         n_cmp = 0, n_bad = 0;
  logic [8:0] mq [$];     // expected FIFO contents, {err, data}
  bit         m_ovr;
  int         pend;       // edges until the pending byte is captured
  logic [8:0] pdata;
  int         tmo;        // idle cycles with a non-empty FIFO

  typedef struct {
    bit         is_pop;
    logic [7:0] d;
    logic       c;
    int         exp_cnt;
  } vec_t;
  vec_t tbl [8];

  task automatic step();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit pop, input bit push, input logic [8:0] w, input bit clr);
    int sz;
    bit acc, ev;
    sz = mq.size(); acc = 0; ev = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) begin mq.push_back(w); acc = 1; end
      else ev = 1;
    end
    if (ev) m_ovr = 1; else if (clr) m_ovr = 0;
    if (acc || pop || sz == 0) tmo = 0;
    else if (tmo < TIMEOUT) tmo++;
  endtask

  // One clock: verify the head being popped, then advance the model.
  task automatic cycle();
    bit pop, push;
    logic [8:0] h;
    pop = rd_if.rd_ready && (mq.size() > 0);
    if (pop) begin
      h = mq[0];
      check("pop_data", rd_if.rd_data, h[7:0]);
      check("pop_err", rd_if.rd_err, h[8]);
    end
    step();
    push = 0;
    if (pend > 0) begin pend--; if (pend == 0) push = 1; end
    model_edge(pop, push, pdata, clr_overrun);
  endtask

  task automatic check_state(input string name);
    check({name, "_count"}, fifo_count, mq.size());
    check({name, "_valid"}, rd_if.rd_valid, mq.size() > 0);
    check({name, "_ovr"}, overrun, m_ovr);
    check({name, "_thr"}, irq_thresh, mq.size() >= THRESH);
    check({name, "_tmo"}, irq_timeout, tmo >= TIMEOUT);
  endtask

  task automatic drive_rise(input logic [7:0] d, input logic c);
    rx_data = d; rx_corrupt = c; rx_done = 1'b1;
    pend = 3; pdata = {c, d};
  endtask

  task automatic send(input logic [7:0] d, input logic c, input bit pop);
    drive_rise(d, c);
    cycle(); cycle();
    rd_if.rd_ready = pop;
    cycle();
    rd_if.rd_ready = 1'b0; rx_done = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    check("pop_valid", rd_if.rd_valid, 1);
    rd_if.rd_ready = 1'b1;
    cycle();
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mq.delete(); m_ovr = 0; tmo = 0; pend = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_wr = 0; cfg_baud_sel = 0; cfg_lcr = 0; rx_active = 0;
    rx_done = 0; rx_data = 0; rx_corrupt = 0; clr_overrun = 0; rd_if.rd_ready = 0;
    m_ovr = 0; pend = 0; tmo = 0;
    tbl[0] = '{0, 8'hA5, 1'b0, 1};
    tbl[1] = '{0, 8'h3C, 1'b1, 2};
    tbl[2] = '{0, 8'hFF, 1'b0, 3};
    tbl[3] = '{1, 8'hA5, 1'b0, 2};
    tbl[4] = '{1, 8'h3C, 1'b1, 1};
    tbl[5] = '{1, 8'hFF, 1'b0, 0};
    tbl[6] = '{0, 8'h00, 1'b1, 1};
    tbl[7] = '{1, 8'h00, 1'b1, 0};

    step();
    do_reset();
    check("rst_baud", baud_sel, 2'b00);
    check("rst_lcr", line_control_reg, 5'b00011);
    check("rst_rx_clr", rx_clr, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_rd_data", rd_if.rd_data, 0);
    check("rst_rd_err", rd_if.rd_err, 0);
    check_state("rst");
    $display("reset values checked");

    // Push latency: captured on the third edge after rx_done rises.
    drive_rise(8'h5A, 1'b0);
    cycle(); cycle();
    check("lat_pre_valid", rd_if.rd_valid, 0);
    cycle();
    check("lat_post_valid", rd_if.rd_valid, 1);
    check("lat_post_data", rd_if.rd_data, 8'h5A);
    rx_done = 1'b0;
    cycle();
    pop_one();
    $display("latency sequence done");

    // Table-driven push/pop vectors.
    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].is_pop) begin
        send(tbl[i].d, tbl[i].c, 0);
      end else begin
        check("tbl_head_data", rd_if.rd_data, tbl[i].d);
        check("tbl_head_err", rd_if.rd_err, tbl[i].c);
        pop_one();
      end
      check("tbl_count", fifo_count, tbl[i].exp_cnt);
      $display("vector %0d pop=%0b data=%02h err=%0b count=%0d", i, tbl[i].is_pop, tbl[i].d, tbl[i].c, fifo_count);
    end

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) send(8'(i * 7 + 1), 1'(i % 2), 0);
    check("ovf_count", fifo_count, 16);
    check("ovf_flag", overrun, 1);
    clr_overrun = 1'b1; cycle(); clr_overrun = 1'b0;
    check("ovf_clr", overrun, 0);
    drive_rise(8'hD0, 1'b0);
    cycle(); cycle();
    clr_overrun = 1'b1; cycle(); clr_overrun = 1'b0;
    check("ovf_clr_race", overrun, 1);
    rx_done = 1'b0; cycle();
    clr_overrun = 1'b1; cycle(); clr_overrun = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_data", rd_if.rd_data, 8'(i * 7 + 1));
      pop_one();
    end
    check_state("ovf_end");
    $display("overflow sequence done");

    // Configuration held off while the receiver is active.
    rx_active = 1'b1;
    cfg_baud_sel = 2'b10; cfg_lcr = 5'b11011; cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    check("cfg_busy_wait", cfg_busy, 1);
    cfg_baud_sel = 2'b01; cfg_lcr = 5'b00001; cfg_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      cfg_wr = 1'b0;
      check("cfg_hold_baud", baud_sel, 2'b00);
      check("cfg_hold_clr", rx_clr, 0);
    end
    rx_active = 1'b0;
    cycle();
    check("cfg_apply_clr", rx_clr, 1);
    cycle();
    check("cfg_post_clr", rx_clr, 0);
    check("cfg_baud", baud_sel, 2'b10);
    check("cfg_lcr", line_control_reg, 5'b11011);
    check("cfg_idle_busy", cfg_busy, 0);
    $display("config baud=%0b lcr=%05b", baud_sel, line_control_reg);

    // Push and pop together at full and at count 1.
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0, 0);
    send(8'hEE, 1'b1, 1);
    check("pp_full_count", fifo_count, 16);
    check("pp_full_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("pp_full_last", rd_if.rd_data, 8'hEE);
      pop_one();
    end
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b0, 1);
    check("pp_one_count", fifo_count, 1);
    check("pp_one_head", rd_if.rd_data, 8'h22);
    check("pp_one_err", rd_if.rd_err, 0);
    pop_one();
    check_state("pp_end");
    $display("push/pop overlap done");

    // Threshold interrupt.
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 1'b0, 0);
      if (i == 6) check("thr_below", irq_thresh, 0);
    end
    check("thr_at", irq_thresh, 1);
    pop_one();
    check("thr_after_pop", irq_thresh, 0);
    for (int i = 0; i < 7; i++) pop_one();
    cycle();

    // Timeout interrupt: one byte, then idle.
    send(8'h77, 1'b0, 0);
    repeat (TIMEOUT - 2) cycle();
    check("tmo_early", irq_timeout, 0);
    cycle();
    check("tmo_hit", irq_timeout, 1);
    repeat (5) cycle();
    check("tmo_sat", irq_timeout, 1);
    pop_one();
    check("tmo_cleared", irq_timeout, 0);
    check_state("tmo_end");
    $display("interrupt sequences done");

    // Long rx_done level gives one push.
    drive_rise(8'h99, 1'b0);
    repeat (50) cycle();
    rx_done = 1'b0;
    cycle(); cycle();
    check("held_count", fifo_count, 1);
    pop_one();

    // Reset in the middle of a pending configuration.
    send(8'h12, 1'b0, 0);
    rx_active = 1'b1;
    cfg_baud_sel = 2'b01; cfg_lcr = 5'h1F; cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    check("mid_busy", cfg_busy, 1);
    do_reset();
    check("mid_rst_busy", cfg_busy, 0);
    check("mid_rst_baud", baud_sel, 2'b00);
    check("mid_rst_lcr", line_control_reg, 5'b00011);
    check("mid_rst_count", fifo_count, 0);
    rx_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("mid_no_apply", rx_clr, 0);
      check("mid_baud", baud_sel, 2'b00);
    end
    $display("reset-mid-config done");

    // Randomized traffic against the reference model.
    begin
      int hi_cnt;
      hi_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
        if (rx_done) begin
          if (hi_cnt >= 3 && $urandom_range(3) == 0) rx_done = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          drive_rise(8'($urandom), 1'($urandom));
          hi_cnt = 0;
        end
        if (n < 1500) rd_if.rd_ready = ($urandom_range(7) == 0);
        else          rd_if.rd_ready = ($urandom_range(3) != 0);
        clr_overrun = ($urandom_range(49) == 0);
        cycle();
        if (rx_done) hi_cnt++;
        check_state("rnd");
        if (n % 500 == 0)
          $display("random cycle %0d count=%0d overrun=%0b", n, fifo_count, overrun);
      end
    end
    rx_done = 1'b0; clr_overrun = 1'b0; rd_if.rd_ready = 1'b0;
    repeat (4) cycle();
    check_state("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
